multicycle_control_fsm: RTL

- Control state machine for the multicycle MIPS-subset CPU.
- Sequences each instruction through fetch, decode, execute, memory and writeback cycles.
- Drives the write enables of the datapath word latches: PC (pc_wren), IR (ir_wren), register file and data memory. Also drives the datapath mux selects.
- Sits directly upstream of the PC and IR word latches. Consumes the latched IR opcode/funct and the ALU zero flag.

---
 rtl/multicycle_control_fsm_pkg.sv | 66 ++++++
 rtl/multicycle_control_fsm_if.sv | 33 +++
 rtl/multicycle_control_fsm_decode.sv | 129 ++++++++++++
 rtl/multicycle_control_fsm.sv | 71 +++++++
 4 files changed

// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings for the multicycle CPU control path: opcodes, functs,
// datapath mux selects, ALU ops, FSM states and the packed control word.
package cpu_defs;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SLT   = 6'h2a;

  typedef enum logic [1:0] {ALU_ADD = 2'd0, ALU_SUB = 2'd1, ALU_XOR = 2'd2, ALU_SLT = 2'd3} alu_op_e;
  typedef enum logic [1:0] {PC_ALU = 2'd0, PC_BRANCH = 2'd1, PC_JUMP = 2'd2, PC_REG = 2'd3} pc_src_e;
  typedef enum logic [1:0] {SRCB_REG = 2'd0, SRCB_FOUR = 2'd1, SRCB_SEXT = 2'd2, SRCB_ZEXT = 2'd3} alu_src_b_e;
  typedef enum logic [1:0] {DST_RT = 2'd0, DST_RD = 2'd1, DST_RA = 2'd2} reg_dst_e;
  typedef enum logic [1:0] {WB_ALU = 2'd0, WB_MEM = 2'd1, WB_LINK = 2'd2} mem_to_reg_e;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_R_WB      = 4'd7,
    S_EXEC_I    = 4'd8,
    S_I_WB      = 4'd9,
    S_BRANCH    = 4'd10,
    S_JUMP      = 4'd11,
    S_JAL       = 4'd12,
    S_JR        = 4'd13,
    S_ILLEGAL   = 4'd14
  } state_e;

  typedef struct packed {
    logic       pc_wren;
    logic       ir_wren;
    logic       reg_wren;
    logic       mem_wren;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       instr_done;
    logic       illegal;
  } ctrl_t;

  function automatic alu_op_e funct_alu_op(input logic [5:0] funct);
    case (funct)
      FN_SUB:  return ALU_SUB;
      FN_SLT:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Controller <-> datapath bundle: IR fields and zero flag in, enables,
// mux selects and debug/status out.
interface multicycle_control_fsm_if;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        zero;
  logic        pc_wren;
  logic        ir_wren;
  logic        reg_wren;
  logic        mem_wren;
  logic [1:0]  pc_src;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  alu_op;
  logic [1:0]  reg_dst;
  logic [1:0]  mem_to_reg;
  logic        instr_done;
  logic        illegal;
  logic [3:0]  state;
  logic [31:0] retire_count;

  modport master (
    input  opcode, funct, zero,
    output pc_wren, ir_wren, reg_wren, mem_wren, pc_src, alu_src_a, alu_src_b,
           alu_op, reg_dst, mem_to_reg, instr_done, illegal, state, retire_count
  );

  modport slave (
    output opcode, funct, zero,
    input  pc_wren, ir_wren, reg_wren, mem_wren, pc_src, alu_src_a, alu_src_b,
           alu_op, reg_dst, mem_to_reg, instr_done, illegal, state, retire_count
  );
endinterface

// File: rtl/multicycle_control_fsm_decode.sv
// Combinational half of the control FSM: current state plus IR fields and
// zero flag produce the control word and the next state.
module control_decode
  import cpu_defs::*;
#(
  parameter bit ILLEGAL_HALT = 1'b1
) (
  input  state_e     state_i,
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  input  logic       zero_i,
  output ctrl_t      ctrl_o,
  output state_e     next_o
);

  logic bad;

  always_comb begin
    ctrl_o = '0;
    next_o = S_FETCH;
    bad    = 1'b0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.ir_wren   = 1'b1;
        ctrl_o.pc_wren   = 1'b1;
        ctrl_o.alu_src_b = SRCB_FOUR;
        next_o           = S_DECODE;
      end
      S_DECODE: begin
        case (opcode_i)
          OP_LW, OP_SW:     next_o = S_MEM_ADDR;
          OP_ADDI, OP_XORI: next_o = S_EXEC_I;
          OP_BNE:           next_o = S_BRANCH;
          OP_J:             next_o = S_JUMP;
          OP_JAL:           next_o = S_JAL;
          OP_RTYPE: begin
            case (funct_i)
              FN_ADD, FN_SUB, FN_SLT: next_o = S_EXEC_R;
              FN_JR:                  next_o = S_JR;
              default:                bad    = 1'b1;
            endcase
          end
          default: bad = 1'b1;
        endcase
        // Undefined instructions either halt for debug or retire as a NOP
        if (bad) begin
          if (ILLEGAL_HALT) begin
            next_o = S_ILLEGAL;
          end else begin
            next_o            = S_FETCH;
            ctrl_o.instr_done = 1'b1;
          end
        end
      end
      S_MEM_ADDR: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_SEXT;
        next_o           = (opcode_i == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: next_o = S_MEM_WB;
      S_MEM_WB: begin
        ctrl_o.reg_wren   = 1'b1;
        ctrl_o.mem_to_reg = WB_MEM;
        ctrl_o.instr_done = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl_o.mem_wren   = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      S_EXEC_R: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_op    = funct_alu_op(funct_i);
        next_o           = S_R_WB;
      end
      S_R_WB: begin
        ctrl_o.reg_wren   = 1'b1;
        ctrl_o.reg_dst    = DST_RD;
        ctrl_o.alu_op     = funct_alu_op(funct_i);
        ctrl_o.instr_done = 1'b1;
      end
      S_EXEC_I, S_I_WB: begin
        ctrl_o.alu_src_a = 1'b1;
        if (opcode_i == OP_XORI) begin
          ctrl_o.alu_src_b = SRCB_ZEXT;
          ctrl_o.alu_op    = ALU_XOR;
        end else begin
          ctrl_o.alu_src_b = SRCB_SEXT;
        end
        if (state_i == S_I_WB) begin
          ctrl_o.reg_wren   = 1'b1;
          ctrl_o.instr_done = 1'b1;
        end else begin
          next_o = S_I_WB;
        end
      end
      S_BRANCH: begin
        ctrl_o.alu_src_a  = 1'b1;
        ctrl_o.alu_op     = ALU_SUB;
        ctrl_o.pc_src     = PC_BRANCH;
        ctrl_o.pc_wren    = ~zero_i;
        ctrl_o.instr_done = 1'b1;
      end
      S_JUMP: begin
        ctrl_o.pc_wren    = 1'b1;
        ctrl_o.pc_src     = PC_JUMP;
        ctrl_o.instr_done = 1'b1;
      end
      S_JAL: begin
        ctrl_o.pc_wren    = 1'b1;
        ctrl_o.pc_src     = PC_JUMP;
        ctrl_o.reg_wren   = 1'b1;
        ctrl_o.reg_dst    = DST_RA;
        ctrl_o.mem_to_reg = WB_LINK;
        ctrl_o.instr_done = 1'b1;
      end
      S_JR: begin
        ctrl_o.pc_wren    = 1'b1;
        ctrl_o.pc_src     = PC_REG;
        ctrl_o.instr_done = 1'b1;
      end
      S_ILLEGAL: begin
        ctrl_o.illegal = 1'b1;
        next_o         = S_ILLEGAL;
      end
      default: next_o = S_FETCH;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle CPU control FSM: state register and retire counter; control
// decode lives in control_decode.
//
// state | meaning
// 0 FETCH | IR <= mem[PC], PC <= PC+4
// 1 DECODE | opcode/funct dispatch
// 2 MEM_ADDR | base + sign-ext offset
// 3 MEM_READ | data memory read
// 4 MEM_WB | rt <= memory data
// 5 MEM_WRITE | memory store
// 6 EXEC_R | R-type ALU op
// 7 R_WB | rd <= ALU out
// 8 EXEC_I | immediate ALU op
// 9 I_WB | rt <= ALU out
// 10 BRANCH | BNE compare, PC <= target if not equal
// 11 JUMP | PC <= jump target
// 12 JAL | PC <= jump target, $31 <= PC
// 13 JR | PC <= rs
// 14 ILLEGAL | sticky halt until reset
module multicycle_control_fsm
  import cpu_defs::*;
#(
  parameter bit ILLEGAL_HALT = 1'b1
) (
  input logic                   clk,
  input logic                   reset,
  multicycle_control_fsm_if.master bus
);

  state_e      state_q, state_d;
  logic [31:0] retire_count_q;
  ctrl_t       ctrl, ctrl_g;

  control_decode #(.ILLEGAL_HALT(ILLEGAL_HALT)) u_decode (
    .state_i  (state_q),
    .opcode_i (bus.opcode),
    .funct_i  (bus.funct),
    .zero_i   (bus.zero),
    .ctrl_o   (ctrl),
    .next_o   (state_d)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_FETCH;
      retire_count_q <= '0;
    end else begin
      state_q <= state_d;
      if (ctrl.instr_done) retire_count_q <= retire_count_q + 32'd1;
    end
  end

  // FETCH would otherwise assert PC/IR writes while reset is still held
  assign ctrl_g = reset ? '0 : ctrl;

  assign bus.pc_wren      = ctrl_g.pc_wren;
  assign bus.ir_wren      = ctrl_g.ir_wren;
  assign bus.reg_wren     = ctrl_g.reg_wren;
  assign bus.mem_wren     = ctrl_g.mem_wren;
  assign bus.pc_src       = ctrl_g.pc_src;
  assign bus.alu_src_a    = ctrl_g.alu_src_a;
  assign bus.alu_src_b    = ctrl_g.alu_src_b;
  assign bus.alu_op       = ctrl_g.alu_op;
  assign bus.reg_dst      = ctrl_g.reg_dst;
  assign bus.mem_to_reg   = ctrl_g.mem_to_reg;
  assign bus.instr_done   = ctrl_g.instr_done;
  assign bus.illegal      = ctrl_g.illegal;
  assign bus.state        = state_q;
  assign bus.retire_count = retire_count_q;

endmodule
